// File: rtl/win3x3_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : win3x3_pkg
// Brief    : Shared sequencer state encoding and frame-size helpers.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
package win3x3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FILL  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic int total_pix(input int w, input int h);
    return w * h;
  endfunction

  // Zero pixels needed to push the last row's centres out of the window.
  function automatic int flush_len(input int w);
    return w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/win3x3_pos_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : win3x3_pos_cnt
// Brief    : Centre row/column counter with wrap and image-border decode.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module win3x3_pos_cnt #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int CW    = 10,
  parameter int RW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          border
);

  localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_H - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (adv) begin
      if (r_col == c_COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign row    = r_row;
  assign col    = r_col;
  assign border = (r_row == '0) || (r_row == c_ROW_LAST) ||
                  (r_col == '0) || (r_col == c_COL_LAST);

endmodule
`default_nettype wire

// File: rtl/win3x3_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : win3x3_seq_ctrl
// Brief    : Frame sequencer for the 3x3 line-buffer window generator.
//            Optional stall counter: WIN3X3_CTRL_STALL_CNT_EN.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module win3x3_seq_ctrl
  import win3x3_pkg::*;
#(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int CW    = 10,
  parameter int RW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          win_ready,
  output logic          shift_en,
  output logic          flush_sel,
  output logic          lb_sclr,
  output logic          win_valid,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          border,
  output logic          busy,
  output logic          frame_done,
`ifdef WIN3X3_CTRL_STALL_CNT_EN
  output logic          err_restart,
  output logic [31:0]   stall_cnt
`else
  output logic          err_restart
`endif
);

  localparam int c_TOTAL_PIX    = total_pix(IMG_W, IMG_H);
  localparam int c_FLUSH_LEN    = flush_len(IMG_W);
  localparam int c_TOTAL_SHIFTS = c_TOTAL_PIX + c_FLUSH_LEN;
  localparam int c_NW_RAW       = $clog2(c_TOTAL_SHIFTS + 1);
  localparam int c_NW           = (c_NW_RAW > 16) ? c_NW_RAW : 16;

  localparam logic [c_NW-1:0] c_FILL_END  = c_NW'(c_FLUSH_LEN);
  localparam logic [c_NW-1:0] c_PIX_END   = c_NW'(c_TOTAL_PIX);
  localparam logic [c_NW-1:0] c_SHIFT_END = c_NW'(c_TOTAL_SHIFTS);

  state_t          r_state;
  state_t          w_next;
  logic [c_NW-1:0] r_n;
  logic [c_NW-1:0] r_in_cnt;
  logic [c_NW-1:0] w_n_inc;
  logic [c_NW-1:0] w_in_inc;
  logic            w_in_ready;
  logic            w_shift;
  logic            w_win_fire;
  logic            w_clr;
  logic [RW-1:0]   w_pos_row;
  logic [CW-1:0]   w_pos_col;
  logic            w_pos_border;
  logic            r_win_valid;
  logic [RW-1:0]   r_win_row;
  logic [CW-1:0]   r_win_col;
  logic            r_border;

  assign w_n_inc  = r_n + c_NW'(1);
  assign w_in_inc = r_in_cnt + c_NW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_shift    = 1'b0;
    flush_sel  = 1'b0;
    lb_sclr    = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      ST_IDLE:  if (frame_start) w_next = ST_CLEAR;
      ST_CLEAR: begin
        lb_sclr = 1'b1;
        w_next  = ST_FILL;
      end
      ST_FILL, ST_RUN: begin
        w_in_ready = win_ready && (r_in_cnt < c_PIX_END);
        w_shift    = in_valid && w_in_ready;
        if (w_shift && (r_state == ST_FILL) && (w_n_inc == c_FILL_END))
          w_next = ST_RUN;
        if (w_shift && (r_state == ST_RUN) && (w_in_inc == c_PIX_END))
          w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_sel = 1'b1;
        w_shift   = win_ready;
        if (win_ready && (w_n_inc == c_SHIFT_END)) w_next = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign in_ready    = w_in_ready;
  assign shift_en    = w_shift;
  assign busy        = (r_state != ST_IDLE);
  assign err_restart = frame_start && busy;
  assign w_clr       = (r_state == ST_CLEAR);
  // Shift number n (1-based) completes a window once n >= IMG_W+2.
  assign w_win_fire  = w_shift && (r_n >= c_FILL_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n      <= '0;
      r_in_cnt <= '0;
    end else if (w_clr) begin
      r_n      <= '0;
      r_in_cnt <= '0;
    end else begin
      if (w_shift)               r_n      <= w_n_inc;
      if (w_in_ready && in_valid) r_in_cnt <= w_in_inc;
    end
  end

  win3x3_pos_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW),
    .RW    (RW)
  ) u_pos_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_clr),
    .adv    (w_win_fire),
    .row    (w_pos_row),
    .col    (w_pos_col),
    .border (w_pos_border)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_border    <= 1'b0;
    end else begin
      r_win_valid <= w_win_fire;
      if (w_win_fire) begin
        r_win_row <= w_pos_row;
        r_win_col <= w_pos_col;
        r_border  <= w_pos_border;
      end
    end
  end

  assign win_valid = r_win_valid;
  assign win_row   = r_win_row;
  assign win_col   = r_win_col;
  assign border    = r_border;

`ifdef WIN3X3_CTRL_STALL_CNT_EN
  logic        w_stall;
  logic [31:0] r_stall_cnt;

  assign w_stall = (((r_state == ST_FILL) || (r_state == ST_RUN)) && in_valid && !win_ready) ||
                   ((r_state == ST_FLUSH) && !win_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_stall_cnt <= '0;
    else if (w_clr)                         r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_win3x3_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_win3x3_seq_ctrl
// Brief    : Directed self-checking bench (4x3 and 5x5 frames).
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_win3x3_seq_ctrl;

  localparam int W = 4, H = 3, TOT = 12, NSH = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic frame_start = 1'b0, frame_start5 = 1'b0, in_valid = 1'b0, win_ready = 1'b0;
  logic in_ready, shift_en, flush_sel, lb_sclr, win_valid, border, busy, frame_done, err_restart;
  logic in_ready5, shift_en5, flush_sel5, lb_sclr5, win_valid5, border5, busy5, frame_done5, err_restart5;
  logic [3:0] win_row, win_col, win_row5, win_col5;
`ifdef WIN3X3_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt, stall_cnt5;
`endif

  int errors = 0;
  int checks = 0;

  win3x3_seq_ctrl #(.IMG_W(W), .IMG_H(H), .CW(4), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
    .in_ready(in_ready), .win_ready(win_ready), .shift_en(shift_en), .flush_sel(flush_sel),
    .lb_sclr(lb_sclr), .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .border(border), .busy(busy), .frame_done(frame_done),
`ifdef WIN3X3_CTRL_STALL_CNT_EN
    .err_restart(err_restart), .stall_cnt(stall_cnt)
`else
    .err_restart(err_restart)
`endif
  );

  win3x3_seq_ctrl #(.IMG_W(5), .IMG_H(5), .CW(4), .RW(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start5), .in_valid(in_valid),
    .in_ready(in_ready5), .win_ready(win_ready), .shift_en(shift_en5), .flush_sel(flush_sel5),
    .lb_sclr(lb_sclr5), .win_valid(win_valid5), .win_row(win_row5), .win_col(win_col5),
    .border(border5), .busy(busy5), .frame_done(frame_done5),
`ifdef WIN3X3_CTRL_STALL_CNT_EN
    .err_restart(err_restart5), .stall_cnt(stall_cnt5)
`else
    .err_restart(err_restart5)
`endif
  );

  // Results of the last run_a frame.
  int m_shifts, m_wins, m_seq_bad, m_first_ok, m_last_row, m_last_col;
  int m_done_cnt, m_done_ok, m_bp_bad, m_orphan, m_ir_bad, m_fs_bad;
  int m_err_cnt, m_err_cyc, m_lb_cnt, m_lb_cyc, m_stall_exp, m_timeout, m_busy_after;

  function automatic bit exp_border(input int r, input int c, input int w, input int h);
    return (r == 0) || (r == h - 1) || (c == 0) || (c == w - 1);
  endfunction

  function automatic logic wr_at(input int c, input int mode);
    return (mode == 0) ? 1'b1 : logic'((c % 2) == 0);
  endfunction

  function automatic logic iv_at(input int c, input int mode);
    return (mode == 0) ? 1'b1 : logic'((c % 3) == 0);
  endfunction

  // Drives one frame into dut and records what was observed, cycle 0 = frame_start.
  task automatic run_a(input int wr_mode, input int iv_mode, input int restart_cyc);
    int acc, prev_shift, prev_idx, cleared;
    logic prev_wr, exp_ir, exp_fs;
    bit done;
    m_shifts = 0; m_wins = 0; m_seq_bad = 0; m_first_ok = 0; m_last_row = -1; m_last_col = -1;
    m_done_cnt = 0; m_done_ok = 0; m_bp_bad = 0; m_orphan = 0; m_ir_bad = 0; m_fs_bad = 0;
    m_err_cnt = 0; m_err_cyc = -1; m_lb_cnt = 0; m_lb_cyc = -1; m_stall_exp = 0; m_timeout = 0;
    acc = 0; prev_shift = 0; prev_idx = 0; cleared = 0; prev_wr = 1'b1; done = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b1; win_ready = wr_at(0, wr_mode); in_valid = iv_at(0, iv_mode);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      exp_ir = logic'(cleared != 0 && acc < TOT) && win_ready;
      exp_fs = logic'(acc == TOT && m_shifts < NSH);
      if (in_ready !== exp_ir) m_ir_bad++;
      if (flush_sel !== exp_fs) m_fs_bad++;
      if (!win_ready && shift_en) m_bp_bad++;
      if (!prev_wr && win_valid) m_bp_bad++;
      if ((cleared != 0 && acc < TOT && in_valid && !win_ready) || (exp_fs && !win_ready))
        m_stall_exp++;
      if (lb_sclr) begin m_lb_cnt++; m_lb_cyc = c; cleared = 1; end
      if (win_valid) begin
        if (prev_shift == 0 || prev_idx < W + 2) m_orphan++;
        if (m_wins == 0 && prev_idx == W + 2) m_first_ok = 1;
        if (int'(win_row) != m_wins / W || int'(win_col) != m_wins % W ||
            border !== exp_border(m_wins / W, m_wins % W, W, H)) m_seq_bad++;
        m_last_row = int'(win_row); m_last_col = int'(win_col);
        m_wins++;
      end
      if (err_restart) begin m_err_cnt++; m_err_cyc = c; end
      if (frame_done) begin
        m_done_cnt++;
        if (prev_shift != 0 && prev_idx == NSH) m_done_ok = 1;
        done = 1'b1;
      end
      prev_shift = int'(shift_en);
      if (shift_en) begin m_shifts++; prev_idx = m_shifts; end
      if (in_valid && in_ready) acc++;
      prev_wr = win_ready;
      @(posedge clk); #1;
      frame_start = logic'(c + 1 == restart_cyc);
      win_ready = wr_at(c + 1, wr_mode);
      in_valid = iv_at(c + 1, iv_mode);
    end
    if (!done) m_timeout = 1;
    frame_start = 1'b0;
    @(negedge clk);
    m_busy_after = int'(busy);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, shift_en, flush_sel, lb_sclr, win_valid, border, busy, frame_done, err_restart} !== 9'b0 ||
        win_row !== 4'd0 || win_col !== 4'd0) begin
      errors++; $display("FAIL reset_outputs: got ctl=%b row=%0d col=%0d want all 0",
        {in_ready, shift_en, flush_sel, lb_sclr, win_valid, border, busy, frame_done, err_restart}, win_row, win_col);
    end
    checks++;
    if ({in_ready5, shift_en5, flush_sel5, lb_sclr5, win_valid5, border5, busy5, frame_done5, err_restart5} !== 9'b0 ||
        win_row5 !== 4'd0 || win_col5 !== 4'd0) begin
      errors++; $display("FAIL reset_outputs5: got ctl=%b want all 0",
        {in_ready5, shift_en5, flush_sel5, lb_sclr5, win_valid5, border5, busy5, frame_done5, err_restart5});
    end
`ifdef WIN3X3_CTRL_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_a(0, 0, -1);
    checks++; if (m_timeout != 0) begin errors++; $display("FAIL basic_timeout: got no frame_done want frame_done"); end
    checks++; if (m_lb_cnt != 1 || m_lb_cyc != 1) begin errors++; $display("FAIL basic_lb_sclr: got cnt=%0d cyc=%0d want cnt=1 cyc=1", m_lb_cnt, m_lb_cyc); end
    checks++; if (m_shifts != NSH) begin errors++; $display("FAIL basic_shifts: got %0d want %0d", m_shifts, NSH); end
    checks++; if (m_wins != TOT) begin errors++; $display("FAIL basic_windows: got %0d want %0d", m_wins, TOT); end
    checks++; if (m_first_ok != 1) begin errors++; $display("FAIL basic_first_win: got %0d want 1", m_first_ok); end
    checks++; if (m_seq_bad != 0 || m_orphan != 0) begin errors++; $display("FAIL basic_win_seq: got bad=%0d orphan=%0d want 0 0", m_seq_bad, m_orphan); end
    checks++; if (m_last_row != 2 || m_last_col != 3) begin errors++; $display("FAIL basic_last_win: got (%0d,%0d) want (2,3)", m_last_row, m_last_col); end
    checks++; if (m_done_cnt != 1 || m_done_ok != 1) begin errors++; $display("FAIL basic_frame_done: got cnt=%0d timing=%0d want 1 1", m_done_cnt, m_done_ok); end
    checks++; if (m_ir_bad != 0 || m_fs_bad != 0) begin errors++; $display("FAIL basic_ready_flush: got ir_bad=%0d fs_bad=%0d want 0 0", m_ir_bad, m_fs_bad); end
    checks++; if (m_err_cnt != 0) begin errors++; $display("FAIL basic_err_restart: got %0d want 0", m_err_cnt); end
    checks++; if (m_busy_after != 0) begin errors++; $display("FAIL basic_busy_after: got %0d want 0", m_busy_after); end
  endtask

  task automatic test_backpressure();
    run_a(1, 0, -1);
    checks++; if (m_timeout != 0) begin errors++; $display("FAIL bp_timeout: got no frame_done want frame_done"); end
    checks++; if (m_shifts != NSH || m_wins != TOT) begin errors++; $display("FAIL bp_totals: got shifts=%0d wins=%0d want %0d %0d", m_shifts, m_wins, NSH, TOT); end
    checks++; if (m_bp_bad != 0) begin errors++; $display("FAIL bp_stall: got %0d violations want 0", m_bp_bad); end
    checks++; if (m_seq_bad != 0 || m_done_ok != 1) begin errors++; $display("FAIL bp_seq: got bad=%0d done_ok=%0d want 0 1", m_seq_bad, m_done_ok); end
    checks++; if (m_ir_bad != 0 || m_fs_bad != 0) begin errors++; $display("FAIL bp_ready_flush: got ir_bad=%0d fs_bad=%0d want 0 0", m_ir_bad, m_fs_bad); end
`ifdef WIN3X3_CTRL_STALL_CNT_EN
    checks++; if (stall_cnt !== 32'(m_stall_exp)) begin errors++; $display("FAIL bp_stall_cnt: got %0d want %0d", stall_cnt, m_stall_exp); end
`endif
  endtask

  task automatic test_restart_err();
    run_a(0, 0, 10);
    checks++; if (m_err_cnt != 1 || m_err_cyc != 10) begin errors++; $display("FAIL restart_err_pulse: got cnt=%0d cyc=%0d want 1 10", m_err_cnt, m_err_cyc); end
    checks++; if (m_shifts != NSH || m_wins != TOT || m_seq_bad != 0) begin errors++; $display("FAIL restart_seq: got shifts=%0d wins=%0d bad=%0d want %0d %0d 0", m_shifts, m_wins, m_seq_bad, NSH, TOT); end
    checks++; if (m_lb_cnt != 1 || m_done_cnt != 1) begin errors++; $display("FAIL restart_frames: got lb=%0d done=%0d want 1 1", m_lb_cnt, m_done_cnt); end
  endtask

  task automatic test_gaps();
    run_a(0, 1, -1);
    checks++; if (m_timeout != 0) begin errors++; $display("FAIL gaps_timeout: got no frame_done want frame_done"); end
    checks++; if (m_ir_bad != 0) begin errors++; $display("FAIL gaps_in_ready: got %0d bad cycles want 0", m_ir_bad); end
    checks++; if (m_shifts != NSH || m_wins != TOT) begin errors++; $display("FAIL gaps_totals: got shifts=%0d wins=%0d want %0d %0d", m_shifts, m_wins, NSH, TOT); end
    checks++; if (m_orphan != 0 || m_seq_bad != 0) begin errors++; $display("FAIL gaps_win_seq: got orphan=%0d bad=%0d want 0 0", m_orphan, m_seq_bad); end
  endtask

  task automatic test_reset_midframe();
    int acc;
    bit saw_done;
    logic pre_wv;
    acc = 0; saw_done = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b1; in_valid = 1'b1; win_ready = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    for (int k = 0; k < 50 && acc < 7; k++) begin
      @(negedge clk);
      if (shift_en) acc++;
      if (frame_done) saw_done = 1'b1;
    end
    checks++; if (acc != 7) begin errors++; $display("FAIL midrst_accept: got %0d pixels want 7", acc); end
    @(posedge clk); #1;
    pre_wv = win_valid;
    checks++; if (pre_wv !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: got win_valid=%b busy=%b want 1 1", pre_wv, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, shift_en, flush_sel, lb_sclr, win_valid, border, busy, frame_done, err_restart} !== 9'b0 ||
        win_row !== 4'd0 || win_col !== 4'd0) begin
      errors++; $display("FAIL midrst_async_clear: got ctl=%b row=%0d col=%0d want all 0",
        {in_ready, shift_en, flush_sel, lb_sclr, win_valid, border, busy, frame_done, err_restart}, win_row, win_col);
    end
    checks++; if (saw_done) begin errors++; $display("FAIL midrst_no_done: got frame_done=1 want 0"); end
    in_valid = 1'b0; win_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_a(0, 0, -1);
    checks++; if (m_first_ok != 1 || m_seq_bad != 0 || m_wins != TOT) begin errors++; $display("FAIL midrst_restart: got first_ok=%0d bad=%0d wins=%0d want 1 0 %0d", m_first_ok, m_seq_bad, m_wins, TOT); end
  endtask

  task automatic test_border_5x5();
    int n, nb, bad;
    bit done;
    n = 0; nb = 0; bad = 0; done = 1'b0;
    @(posedge clk); #1;
    frame_start5 = 1'b1; in_valid = 1'b1; win_ready = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (win_valid5) begin
        if (int'(win_row5) != n / 5 || int'(win_col5) != n % 5) bad++;
        if (!border5) begin
          nb++;
          if (n / 5 < 1 || n / 5 > 3 || n % 5 < 1 || n % 5 > 3) bad++;
        end
        n++;
      end
      if (frame_done5) done = 1'b1;
      @(posedge clk); #1 frame_start5 = 1'b0;
    end
    checks++; if (!done) begin errors++; $display("FAIL b5_timeout: got no frame_done want frame_done"); end
    checks++; if (n != 25) begin errors++; $display("FAIL b5_windows: got %0d want 25", n); end
    checks++; if (nb != 9) begin errors++; $display("FAIL b5_interior: got %0d want 9", nb); end
    checks++; if (bad != 0) begin errors++; $display("FAIL b5_positions: got %0d bad want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_restart_err();
    test_gaps();
    test_reset_midframe();
    test_border_5x5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
